// File: rtl/mem_arbiter_n_pkg.sv
// mem_arbiter_n_pkg: shared state encoding and helpers for the L1-to-L2 line arbiter
package mem_arbiter_n_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_e;
   localparam int LINE_WIDTH_DEF = 256;
   function automatic int wrap_inc(input int v, input int n);
      return (v >= n - 1) ? 0 : v + 1;
   endfunction
endpackage

// File: rtl/mem_arbiter_n_rr_picker.sv
// mem_arbiter_n_rr_picker: combinational winner select, round-robin from ptr or fixed priority from port 0
module mem_arbiter_n_rr_picker #(
   parameter int NUM_PORTS = 2
) (
   input  logic [NUM_PORTS-1:0]         req,
   input  logic [$clog2(NUM_PORTS)-1:0] ptr,
   input  logic                         mode,
   output logic [$clog2(NUM_PORTS)-1:0] winner,
   output logic                         valid
);
   localparam int IW = $clog2(NUM_PORTS);
   logic [2*NUM_PORTS-1:0] dbl;
   logic [IW-1:0]          base;
   assign dbl   = {req, req};
   assign base  = mode ? ptr : '0;
   assign valid = |req;
   // scan the doubled vector downward so the first set bit at or after base wins
   always_comb begin
      winner = '0;
      for (int k = 2*NUM_PORTS-1; k >= 0; k--)
         if (dbl[k] && k >= int'(base) && k < int'(base) + NUM_PORTS) winner = IW'(k % NUM_PORTS);
   end
endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: serialises whole-line L1 read/write transactions onto one L2 port
module mem_arbiter_n
   import mem_arbiter_n_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int RR_MODE    = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             up_read,
   input  logic [NUM_PORTS-1:0]             up_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  up_addr,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  up_wdata,
   output logic [LINE_WIDTH-1:0]            up_rdata,
   output logic [NUM_PORTS-1:0]             up_resp,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic                             mem_read,
   output logic                             mem_write,
   output logic [LINE_WIDTH-1:0]            mem_wdata,
   input  logic [LINE_WIDTH-1:0]            mem_rdata,
   input  logic                             mem_resp,
   output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
   output logic                             busy
);
   localparam int IW = $clog2(NUM_PORTS);
   arb_state_e           state;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        win;
   logic                 win_valid;
   logic [NUM_PORTS-1:0] req;
   assign req      = up_read | up_write;
   assign up_rdata = mem_rdata;
   mem_arbiter_n_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .mode   (RR_MODE != 0),
      .winner (win),
      .valid  (win_valid)
   );
   // completion pulse goes only to the port holding the grant, and only in BUSY
   always_comb up_resp = (state == BUSY && mem_resp) ? (NUM_PORTS'(1) << grant_id) : '0;
   // FSM; mem_address/mem_wdata double as the holding registers for the granted request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (win_valid) begin
               mem_address <= up_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wdata   <= up_wdata[win*LINE_WIDTH +: LINE_WIDTH];
               mem_write   <= up_write[win];
               mem_read    <= ~up_write[win];
               grant_id    <= win;
               busy        <= 1'b1;
               state       <= BUSY;
            end
            BUSY: if (mem_resp) begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               busy      <= 1'b0;
               rr_ptr    <= IW'(wrap_inc(int'(grant_id), NUM_PORTS));
               state     <= RELEASE;
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised N-port arbiter between the L1 caches (icache, dcache, future prefetch/victim ports) and the L2 cache.
- Serialises whole-line read/write transactions onto one downstream port.
- Selectable fixed-priority or round-robin policy.
- Latches the granted request so upstream ports cannot corrupt an in-flight transaction.

Parameters:
NUM_PORTS, 2, number of upstream requesters (2..8); port 0 has highest fixed priority
ADDR_WIDTH, 32, address width
LINE_WIDTH, 256, cache line width
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
up_read  input  NUM_PORTS  per-port line read request
up_write  input  NUM_PORTS  per-port line write request
up_addr  input  NUM_PORTS*ADDR_WIDTH  per-port line address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
up_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line, packed the same way
up_rdata  output  LINE_WIDTH  read line, broadcast to all ports
up_resp  output  NUM_PORTS  one-hot completion pulse to the granted port
mem_address  output  ADDR_WIDTH  downstream address
mem_read  output  1  downstream read
mem_write  output  1  downstream write
mem_wdata  output  LINE_WIDTH  downstream write line
mem_rdata  input  LINE_WIDTH  downstream read line
mem_resp  input  1  downstream completion
grant_id  output  $clog2(NUM_PORTS)  index of the current/last grant
busy  output  1  transaction in flight

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; rr_ptr=0; grant_id=0.
  - mem_read/mem_write=0; mem_address=0; mem_wdata=0; up_resp=0; busy=0.
- Request vector: req[i] = up_read[i] | up_write[i].
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any req bit is set, select winner g:
    - RR_MODE=1: first set bit at or after rr_ptr, scanning upward with wrap from NUM_PORTS-1 to 0.
    - RR_MODE=0: lowest set index.
  - Register addr[g], wdata[g], op into holding registers; grant_id<=g; go to BUSY.
  - If both up_read[g] and up_write[g] are set, write is taken (illegal combination; bench flags it).
- BUSY:
  - mem_read/mem_write driven from the held op; mem_address/mem_wdata from holding registers; busy=1.
  - Latency: request sampled in cycle n gives the downstream strobe in cycle n+1.
  - Upstream inputs are ignored while in BUSY.
  - Stay in BUSY until mem_resp=1.
  - In the mem_resp cycle, combinationally: up_resp[grant_id]=1, up_rdata=mem_rdata.
  - Then go to RELEASE; rr_ptr <= (grant_id+1) mod NUM_PORTS, with explicit wrap for non-power-of-2 NUM_PORTS.
- RELEASE:
  - One cycle; mem_read/mem_write=0; up_resp=0; busy=0.
  - Gives the served cache one cycle to drop its request before re-arbitration; then go to IDLE.
- Minimum spacing: two downstream transactions are separated by at least 2 idle cycles (RELEASE, IDLE).
- Requester drops its request while BUSY: transaction still runs to mem_resp (downstream cannot abort); up_resp still pulses; result is discarded by the requester.
- New requests arriving during BUSY/RELEASE: wait; no request is lost while it is held.
- Starvation bound (RR_MODE=1): a held request is granted within NUM_PORTS-1 other transactions.
- mem_resp outside BUSY: ignored.
- up_rdata outside the resp cycle: equals mem_rdata, not qualified.
- Reset mid-transaction: immediate return to IDLE with all outputs cleared; no up_resp is generated for the aborted grant.

Decomposition:
- Shared package (rv32i_types or a mem package): arb_state_e enum {IDLE, BUSY, RELEASE}; LINE_WIDTH default constant 256.
- Sub-module rr_picker: combinational, parametrised by NUM_PORTS; inputs req vector, rr_ptr, mode; outputs winner index and valid.
- Top level mem_arbiter_n holds the FSM, holding registers and rr_ptr.

Test Plan:
- NUM_PORTS=2, RR: port0 read 0x0000_0100, mem_resp after 5 cycles with data 0xAA..AA -> mem_read in cycles 1-6, up_resp=2'b01 and up_rdata=0xAA..AA in cycle 6, rr_ptr=1.
- NUM_PORTS=2, RR: both ports request continuously -> grants alternate 0,1,0,1; each grant follows the previous resp by exactly 2 cycles.
- NUM_PORTS=4, RR_MODE=0: ports 1 and 3 requesting, port 1 re-requests after each resp -> port 3 never granted (fixed priority confirmed); same stimulus with RR_MODE=1 -> port 3 granted second.
- Port 1 write 0x0000_2000, data 0x55..55, then changes up_addr to 0xFFFF_FFE0 in BUSY -> mem_address stays 0x0000_2000 and mem_wdata stays 0x55..55 until mem_resp.
- Reset asserted in BUSY cycle 3 -> outputs zero in the same cycle (asynchronous); later mem_resp produces no up_resp; after release the next grant goes to port 0.
- NUM_PORTS=3, RR: grant port 2 completes -> rr_ptr wraps to 0; a simultaneous request from ports 0 and 2 grants port 0.
